conv_mac_stream: RTL
====================

Name: conv_mac_stream

Overview:
- Streaming signed multiply-accumulate stage of the 2D convolution datapath.
- Consumes one (input pixel, kernel weight) pair per cycle and sums K*K consecutive products into one output pixel.
- Presents each finished output pixel on an AXI-stream style transmit interface that feeds the output FIFO directly.
- Full-pipeline stall on output backpressure: no pair is ever lost or duplicated.

Parameters:
- INW, 8, bit width of each signed input pixel and each signed weight.
- OUTW, 24, bit width of each signed output pixel; must satisfy OUTW >= 2*INW.
- K, 4, kernel dimension; one output pixel per K*K accepted pairs; K >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_x  input  INW  signed input pixel.
- in_w  input  INW  signed kernel weight, paired with in_x.
- in_valid  input  1  upstream has a valid pair.
- in_ready  output  1  block accepts a pair this cycle.
- OUT_AXIS_TDATA  output  OUTW  signed output pixel.
- OUT_AXIS_TVALID  output  1  OUT_AXIS_TDATA holds a finished pixel.
- OUT_AXIS_TREADY  input  1  downstream FIFO accepts the pixel.

Behaviour:
- Handshakes:
  - Pair accepted when in_valid && in_ready.
  - Pixel transferred when OUT_AXIS_TVALID && OUT_AXIS_TREADY.
  - TVALID never depends combinationally on TREADY.
- Global enable en = !(OUT_AXIS_TVALID && !OUT_AXIS_TREADY). in_ready = en, a combinational function of registered TVALID and TREADY only, never of in_valid.
- When en is low, every pipeline register holds its value: product stage, accumulator, counter, output register.
- Stage 1, product, on en:
  - p_valid <= in_valid.
  - p <= signed(in_x) * signed(in_w), full 2*INW bits.
- Stage 2, accumulate, on en && p_valid:
  - pe = p sign-extended to OUTW.
  - If cnt == 0, acc <= pe; otherwise acc <= acc + pe.
  - cnt <= (cnt == K*K-1) ? 0 : cnt + 1.
  - cnt width is $clog2(K*K), minimum 1 bit.
- Output register, on en:
  - OUT_AXIS_TVALID <= p_valid && (cnt == K*K-1).
  - When that condition is true, OUT_AXIS_TDATA <= (cnt == 0 ? pe : acc + pe). This makes K=1 pass each product straight through.
  - Otherwise OUT_AXIS_TDATA holds its value.
- Arithmetic: all sums are two's complement modulo 2^OUTW; overflow wraps silently, with no saturation and no flag.
- Latency: the K*K-th pair of a window is accepted in cycle t; OUT_AXIS_TVALID = 1 from cycle t+2, provided no stall occurs.
- Throughput: one pair per cycle sustained while TREADY = 1, including back-to-back windows with no bubble.
- Stall: while TVALID = 1 and TREADY = 0:
  - in_ready = 0.
  - TDATA stable.
  - The pair held in stage 1 is neither dropped nor counted twice.
- Simultaneous transfer and new result: if TVALID = 1 and TREADY = 1 in the same cycle that stage 2 completes a window, the new pixel is loaded into the output register that cycle. This gives one pixel per cycle at K=1.
- Bubbles: in_valid = 0 cycles insert bubbles (p_valid = 0). They do not advance cnt and do not disturb acc.
- Reset:
  - p_valid = 0, p = 0, acc = 0, cnt = 0, OUT_AXIS_TVALID = 0, OUT_AXIS_TDATA = 0.
  - in_ready = 1 in the first cycle after reset.
  - A reset mid-window discards the partial sum. The next accepted pair starts a new window.

Test Plan:
- Basic sum: defaults, 16 pairs x=1 w=1 back-to-back, TREADY=1 -> exactly one pixel, TDATA=16, TVALID rises 2 cycles after the 16th accept.
- Signed operands: 16 pairs x=-128 w=127 -> TDATA = -260096 (24'hFC0800). Then 16 pairs x=-3 w=-5 -> TDATA = 240, with no idle cycle between windows.
- Stall: hold TREADY=0 for 5 cycles while a pixel is valid with in_valid=1 continuously -> in_ready=0 and TDATA stable for all 5 cycles. After release, the next window still sums to its exact value (16 with all-ones pairs) and no pairs are lost.
- Wrap-around: OUTW=16, 16 pairs x=-128 w=-128 -> TDATA = 0 (262144 mod 65536); a further 16 pairs x=1 w=1 -> TDATA = 16.
- Reset mid-window: accept 7 pairs of value 9, assert reset for 1 cycle, then 16 pairs x=2 w=3 -> single pixel TDATA = 96; TVALID = 0 throughout reset.
- K=1 and bubbles: with K=1, pairs (5,6), bubble, (-2,7) with TREADY=1 -> pixels 30 then -14, each 2 cycles after its accept. With defaults, in_valid toggling every cycle over 32 cycles -> one pixel, equal to the sum of the 16 accepted products.

Source files
------------

// File: rtl/conv_mac_stream.sv
// Streaming signed multiply-accumulate stage: sums K*K consecutive (pixel, weight)
// products into one output pixel, delivered on an AXI-stream style transmit port.
module conv_mac_stream #(
  parameter int INW  = 8,
  parameter int OUTW = 24,
  parameter int K    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INW-1:0]    in_x,
  input  logic [INW-1:0]    in_w,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUTW-1:0]   OUT_AXIS_TDATA,
  output logic              OUT_AXIS_TVALID,
  input  logic              OUT_AXIS_TREADY
);

  localparam int NPAIR = K * K;
  localparam int CW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NPAIR - 1);

  logic                     en;
  logic                     p_valid;
  logic signed [2*INW-1:0]  x_ext;
  logic signed [2*INW-1:0]  w_ext;
  logic signed [2*INW-1:0]  p;
  logic signed [OUTW-1:0]   pe;
  logic signed [OUTW-1:0]   acc;
  logic signed [OUTW-1:0]   sum;
  logic [CW-1:0]            cnt;
  logic                     win_done;

  // One enable freezes the whole pipeline while a finished pixel waits downstream.
  assign en       = !(OUT_AXIS_TVALID && !OUT_AXIS_TREADY);
  assign in_ready = en;

  assign x_ext    = (2*INW)'($signed(in_x));
  assign w_ext    = (2*INW)'($signed(in_w));
  assign pe       = OUTW'(p);
  assign sum      = (cnt == '0) ? pe : acc + pe;
  assign win_done = p_valid && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid         <= 1'b0;
      p               <= '0;
      acc             <= '0;
      cnt             <= '0;
      OUT_AXIS_TVALID <= 1'b0;
      OUT_AXIS_TDATA  <= '0;
    end else if (en) begin
      p_valid <= in_valid;
      p       <= x_ext * w_ext;
      if (p_valid) begin
        acc <= sum;
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
      // The finishing sum bypasses acc so K=1 and back-to-back windows need no bubble.
      OUT_AXIS_TVALID <= win_done;
      if (win_done) begin
        OUT_AXIS_TDATA <= sum;
      end
    end
  end

endmodule
